ibex_multdiv_issue: RTL and testbench
=====================================

IBEX_MULTDIV_ISSUE -- requirements
Module: ibex_multdiv_issue

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the per-operation cycle counter.
REQ-002 SHALL have clk_i  in  1  clock; all state on rising edge.
REQ-003 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i in 1 / req_ready_o out 1: request handshake from the decode stage.
REQ-005 SHALL have req_operator_i in 2, req_signed_mode_i in 2, req_op_a_i in 32, req_op_b_i in 32, req_rd_i in 5: operation payload.
  - Operator encoding: MULL=0, MULH=1, DIV=2, REM=3.
  - signed_mode bit0 = op_a signed; bit1 = op_b signed.
REQ-006 SHALL have flush_i  in  1  pipeline kill.
REQ-007 SHALL have md_mult_en_o out 1, md_div_en_o out 1, md_operator_o out 2, md_signed_mode_o out 2, md_op_a_o out 32, md_op_b_o out 32, md_equal_to_zero_o out 1: multdiv unit drive.
REQ-008 SHALL have md_result_i in 32 and md_valid_i in 1: multdiv unit return.
REQ-009 SHALL have rsp_valid_o out 1, rsp_ready_i in 1, rsp_result_o out 32, rsp_rd_o out 5: writeback handshake.
REQ-010 SHALL have busy_o out 1 and cycles_o out CNT_W: status and last-operation latency.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DRAIN, RESP.
REQ-012 SHALL assert req_ready_o only in IDLE.
REQ-013 SHALL accept a request on req_valid_i & req_ready_o & !flush_i.
  - On accept: register operator, signed_mode, op_a, op_b, rd; register equal_to_zero = (req_op_b_i == 0); clear counter; go BUSY.
REQ-014 SHALL drive md_op_a_o, md_op_b_o, md_operator_o, md_signed_mode_o and md_equal_to_zero_o from registers only.
  - These SHALL be held constant from accept until the next accept.
REQ-015 SHALL assert md_mult_en_o iff state is BUSY or DRAIN and the latched operator is MULL/MULH.
REQ-016 SHALL assert md_div_en_o iff state is BUSY or DRAIN and the latched operator is DIV/REM; enables SHALL never both be high.
REQ-017 SHALL, in BUSY with md_valid_i=1, capture md_result_i into rsp_result_o in that same cycle and go RESP.
REQ-018 SHALL increment the counter on every BUSY cycle including the md_valid_i cycle, saturating at 2^CNT_W-1.
  - cycles_o = counter value, stable outside BUSY.
REQ-019 SHALL, in RESP, assert rsp_valid_o and hold rsp_result_o/rsp_rd_o stable until rsp_ready_i=1, then go IDLE.
  - No new request is accepted in that cycle.
REQ-020 SHALL, on flush_i in BUSY without md_valid_i, go DRAIN.
  - Enables stay asserted so the multdiv unit FSM returns to its idle state.
REQ-021 SHALL, on flush_i in BUSY with md_valid_i, discard the result and go IDLE.
REQ-022 SHALL, in DRAIN, ignore flush_i, discard md_result_i, and go IDLE on md_valid_i; rsp_valid_o SHALL remain 0.
REQ-023 SHALL, on flush_i in RESP, drop the response and go IDLE with rsp_valid_o=0 next cycle.
REQ-024 SHALL ignore md_valid_i in IDLE and RESP.
REQ-025 SHALL assert busy_o in BUSY, DRAIN and RESP.

Reset
REQ-026 SHALL, on rst_ni low, go IDLE asynchronously, including mid-operation.
  - md_mult_en_o=0, md_div_en_o=0, rsp_valid_o=0, busy_o=0, req_ready_o=1.
  - All payload registers, rsp_result_o, rsp_rd_o and cycles_o SHALL be 0.
REQ-027 SHALL present first-cycle-after-reset behaviour identical to IDLE; the multdiv unit is reset by the same rst_ni.

Verification
REQ-028 SHALL cover MULL: a=7, b=6, rd=3 with a real multdiv unit -> rsp_result_o=42, rsp_rd_o=3, cycles_o=3.
REQ-029 SHALL cover MULH signed: a=0x80000000, b=2, signed_mode=3 -> rsp_result_o=0xFFFFFFFF, cycles_o=4.
REQ-030 SHALL cover DIV by zero: a=5, b=0 -> md_equal_to_zero_o=1, rsp_result_o=0xFFFFFFFF, cycles_o=2.
REQ-031 SHALL cover flush mid-operation: DIV 100/7, flush_i pulsed in 5th BUSY cycle -> DRAIN, no rsp_valid_o.
  - Following REM 100/7 SHALL return 2.
REQ-032 SHALL cover backpressure: rsp_ready_i=0 for 10 cycles after MULL 3*4 -> rsp_valid_o held, result 12 stable, req_ready_o=0 throughout.
REQ-033 SHALL cover reset mid-DIV: rst_ni low in cycle 10 of BUSY -> all outputs at reset values.
  - Next MULL 2*2 SHALL return 4 with cycles_o=3.

Source files
------------

// File: rtl/ibex_multdiv_issue_if.sv
// ibex_multdiv_issue_if: decode request, multdiv unit drive/return and writeback signals
// bundled between the issue stage and its environment.
interface ibex_multdiv_issue_if #(
    parameter int CNT_W = 16
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_operator_i;
    logic [1:0]       req_signed_mode_i;
    logic [31:0]      req_op_a_i;
    logic [31:0]      req_op_b_i;
    logic [4:0]       req_rd_i;
    logic             flush_i;
    logic             md_mult_en_o;
    logic             md_div_en_o;
    logic [1:0]       md_operator_o;
    logic [1:0]       md_signed_mode_o;
    logic [31:0]      md_op_a_o;
    logic [31:0]      md_op_b_o;
    logic             md_equal_to_zero_o;
    logic [31:0]      md_result_i;
    logic             md_valid_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic [4:0]       rsp_rd_o;
    logic             busy_o;
    logic [CNT_W-1:0] cycles_o;

    modport slave (
        input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
               req_rd_i, flush_i, md_result_i, md_valid_i, rsp_ready_i,
        output req_ready_o, md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
               md_op_a_o, md_op_b_o, md_equal_to_zero_o, rsp_valid_o, rsp_result_o,
               rsp_rd_o, busy_o, cycles_o
    );

    modport master (
        output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
               req_rd_i, flush_i, md_result_i, md_valid_i, rsp_ready_i,
        input  req_ready_o, md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o,
               md_op_a_o, md_op_b_o, md_equal_to_zero_o, rsp_valid_o, rsp_result_o,
               rsp_rd_o, busy_o, cycles_o
    );
endinterface

// File: rtl/ibex_multdiv_issue.sv
// ibex_multdiv_issue: holds one mult/div operation stable for the multdiv unit, returns its
// result over a writeback handshake and records how many cycles the unit took.
module ibex_multdiv_issue #(
    parameter int CNT_W = 16
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    ibex_multdiv_issue_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       operator_q, operator_d;
    logic [1:0]       signed_mode_q, signed_mode_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [4:0]       rd_q, rd_d;
    logic             eq_zero_q, eq_zero_d;
    logic [31:0]      result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_active;

    always_comb begin
        state_d       = state_q;
        operator_d    = operator_q;
        signed_mode_d = signed_mode_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        rd_d          = rd_q;
        eq_zero_d     = eq_zero_q;
        result_d      = result_q;
        cnt_d         = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    operator_d    = bus.req_operator_i;
                    signed_mode_d = bus.req_signed_mode_i;
                    op_a_d        = bus.req_op_a_i;
                    op_b_d        = bus.req_op_b_i;
                    rd_d          = bus.req_rd_i;
                    eq_zero_d     = bus.req_op_b_i == '0;
                    cnt_d         = '0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (bus.md_valid_i && !bus.flush_i) begin
                    result_d = bus.md_result_i;
                    state_d  = RESP;
                end else if (bus.md_valid_i) begin
                    state_d = IDLE;
                end else if (bus.flush_i) begin
                    state_d = DRAIN;
                end
            end
            // Keep the unit enabled until it reports done so its own FSM unwinds cleanly.
            DRAIN:   state_d = bus.md_valid_i ? IDLE : DRAIN;
            default: state_d = (bus.flush_i || bus.rsp_ready_i) ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            operator_q    <= '0;
            signed_mode_q <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            rd_q          <= '0;
            eq_zero_q     <= 1'b0;
            result_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            operator_q    <= operator_d;
            signed_mode_q <= signed_mode_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            rd_q          <= rd_d;
            eq_zero_q     <= eq_zero_d;
            result_q      <= result_d;
            cnt_q         <= cnt_d;
        end
    end

    assign md_active              = state_q == BUSY || state_q == DRAIN;
    assign bus.req_ready_o        = state_q == IDLE;
    assign bus.md_mult_en_o       = md_active && !operator_q[1];
    assign bus.md_div_en_o        = md_active && operator_q[1];
    assign bus.md_operator_o      = operator_q;
    assign bus.md_signed_mode_o   = signed_mode_q;
    assign bus.md_op_a_o          = op_a_q;
    assign bus.md_op_b_o          = op_b_q;
    assign bus.md_equal_to_zero_o = eq_zero_q;
    assign bus.rsp_valid_o        = state_q == RESP;
    assign bus.rsp_result_o       = result_q;
    assign bus.rsp_rd_o           = rd_q;
    assign bus.busy_o             = state_q != IDLE;
    assign bus.cycles_o           = cnt_q;
endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// tb_ibex_multdiv_issue: drives the issue stage against a behavioural multdiv unit with fixed
// latencies and checks results, latencies and handshake behaviour against arithmetic references.
module tb_ibex_multdiv_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_multdiv_issue_if #(.CNT_W(16)) bus ();
    ibex_multdiv_issue #(.CNT_W(16)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    int total = 0;
    int passed = 0;

    // RISC-V M-extension results from plain wide arithmetic
    function automatic logic [31:0] mdref(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] pa, pb, p, q, r;
        pa = {{34{sm[0] & a[31]}}, a};
        pb = {{34{sm[1] & b[31]}}, b};
        p  = pa * pb;
        if (op == 2'd0) return p[31:0];
        if (op == 2'd1) return p[63:32];
        if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
        q = pa / pb;
        r = pa % pb;
        return (op == 2'd2) ? q[31:0] : r[31:0];
    endfunction

    function automatic int unit_lat(input logic [1:0] op, input logic zero);
        return (op == 2'd0) ? 3 : (op == 2'd1) ? 4 : zero ? 2 : 35;
    endfunction

    // Behavioural multdiv unit: answers after a fixed number of enabled cycles
    logic [7:0] mu_cnt;
    logic       mu_en;
    assign mu_en = bus.md_mult_en_o | bus.md_div_en_o;
    always_comb begin
        bus.md_valid_i  = mu_en && int'(mu_cnt) == unit_lat(bus.md_operator_o, bus.md_equal_to_zero_o) - 1;
        bus.md_result_i = bus.md_valid_i ? mdref(bus.md_operator_o, bus.md_signed_mode_o,
                                                 bus.md_op_a_o, bus.md_op_b_o) : 32'hDEAD_BEEF;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mu_cnt <= '0;
        else        mu_cnt <= (mu_en && !bus.md_valid_i) ? mu_cnt + 8'd1 : 8'd0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.req_operator_i    = op;
        bus.req_signed_mode_i = sm;
        bus.req_op_a_i        = a;
        bus.req_op_b_i        = b;
        bus.req_rd_i          = rd;
        bus.req_valid_i       = 1'b1;
        step();
        bus.req_valid_i       = 1'b0;
        bus.req_op_a_i        = $urandom;
        bus.req_op_b_i        = $urandom;
        bus.req_rd_i          = 5'($urandom);
    endtask

    task automatic wait_rsp(output bit got);
        for (int n = 0; n < 200 && !bus.rsp_valid_o; n++) step();
        got = bus.rsp_valid_o;
    endtask

    task automatic release_rsp();
        bus.rsp_ready_i = 1'b1;
        step();
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.req_ready_o, bus.busy_o, bus.md_mult_en_o, bus.md_div_en_o, bus.rsp_valid_o} !== 5'b10000) begin
            $display("FAIL reset_ctrl: got %b want 10000", {bus.req_ready_o, bus.busy_o, bus.md_mult_en_o, bus.md_div_en_o, bus.rsp_valid_o});
        end else passed++;
        total++;
        if ({bus.md_op_a_o, bus.md_op_b_o, bus.rsp_result_o, bus.rsp_rd_o, bus.cycles_o,
             bus.md_operator_o, bus.md_signed_mode_o, bus.md_equal_to_zero_o} !== '0) begin
            $display("FAIL reset_payload: a=%h b=%h res=%h rd=%0d cyc=%0d", bus.md_op_a_o, bus.md_op_b_o, bus.rsp_result_o, bus.rsp_rd_o, bus.cycles_o);
        end else passed++;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [3] = '{2'd0, 2'd1, 2'd2};
        logic [1:0]  sms [3] = '{2'd0, 2'd3, 2'd3};
        logic [31:0] as  [3] = '{32'd7, 32'h8000_0000, 32'd5};
        logic [31:0] bs  [3] = '{32'd6, 32'd2, 32'd0};
        logic [4:0]  rds [3] = '{5'd3, 5'd9, 5'd12};
        logic [31:0] res [3] = '{32'd42, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int          cyc [3] = '{3, 4, 2};
        bit got;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], sms[i], as[i], bs[i], rds[i]);
            total++;
            if ({bus.md_mult_en_o, bus.md_div_en_o, bus.md_equal_to_zero_o} !== {ops[i] < 2, ops[i] >= 2, bs[i] == 0}) begin
                $display("FAIL dir%0d_enables: mult=%b div=%b eqz=%b", i, bus.md_mult_en_o, bus.md_div_en_o, bus.md_equal_to_zero_o);
            end else passed++;
            wait_rsp(got);
            total++;
            if (!got || bus.rsp_result_o !== res[i] || bus.rsp_rd_o !== rds[i]) begin
                $display("FAIL dir%0d_rsp: valid=%b res=%h rd=%0d want res=%h rd=%0d", i, got, bus.rsp_result_o, bus.rsp_rd_o, res[i], rds[i]);
            end else passed++;
            total++;
            if (int'(bus.cycles_o) != cyc[i]) begin
                $display("FAIL dir%0d_cycles: got %0d want %0d", i, bus.cycles_o, cyc[i]);
            end else passed++;
            release_rsp();
            total++;
            if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
                $display("FAIL dir%0d_release: rsp_valid=%b req_ready=%b", i, bus.rsp_valid_o, bus.req_ready_o);
            end else passed++;
        end
    endtask

    task automatic test_flush();
        bit got;
        bit seen = 1'b0;
        issue(2'd2, 2'd3, 32'd100, 32'd7, 5'd4);
        repeat (4) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        total++;
        if ({bus.busy_o, bus.md_div_en_o, bus.rsp_valid_o, bus.req_ready_o} !== 4'b1100) begin
            $display("FAIL flush_drain: busy=%b div_en=%b rsp_valid=%b req_ready=%b want 1100", bus.busy_o, bus.md_div_en_o, bus.rsp_valid_o, bus.req_ready_o);
        end else passed++;
        for (int n = 0; n < 100 && !bus.req_ready_o; n++) begin
            bus.flush_i = n[0];
            seen |= bus.rsp_valid_o;
            step();
        end
        bus.flush_i = 1'b0;
        total++;
        if (seen || bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
            $display("FAIL flush_return: rsp_seen=%b req_ready=%b", seen, bus.req_ready_o);
        end else passed++;
        total++;
        if (int'(bus.cycles_o) != 5) begin
            $display("FAIL flush_cycles: got %0d want 5", bus.cycles_o);
        end else passed++;
        issue(2'd3, 2'd3, 32'd100, 32'd7, 5'd8);
        wait_rsp(got);
        total++;
        if (!got || bus.rsp_result_o !== 32'd2 || bus.rsp_rd_o !== 5'd8) begin
            $display("FAIL flush_rem: valid=%b res=%0d rd=%0d want 2 rd=8", got, bus.rsp_result_o, bus.rsp_rd_o);
        end else passed++;
        release_rsp();
    endtask

    task automatic test_backpressure();
        bit got;
        bit bad = 1'b0;
        issue(2'd0, 2'd0, 32'd3, 32'd4, 5'd7);
        wait_rsp(got);
        bus.req_operator_i = 2'd0;
        bus.req_op_a_i     = 32'd9;
        bus.req_op_b_i     = 32'd9;
        bus.req_valid_i    = 1'b1;
        for (int n = 0; n < 10; n++) begin
            bad |= !bus.rsp_valid_o || bus.rsp_result_o !== 32'd12 || bus.req_ready_o !== 1'b0 || bus.rsp_rd_o !== 5'd7;
            step();
        end
        total++;
        if (!got || bad) begin
            $display("FAIL bp_hold: valid=%b res=%0d req_ready=%b bad=%b want res 12", bus.rsp_valid_o, bus.rsp_result_o, bus.req_ready_o, bad);
        end else passed++;
        release_rsp();
        total++;
        if ({bus.busy_o, bus.req_ready_o, bus.rsp_valid_o} !== 3'b010) begin
            $display("FAIL bp_no_accept: busy=%b req_ready=%b rsp_valid=%b want 010", bus.busy_o, bus.req_ready_o, bus.rsp_valid_o);
        end else passed++;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit got;
        issue(2'd2, 2'd0, $urandom, 32'd13, 5'd21);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ready_o, bus.busy_o, bus.md_mult_en_o, bus.md_div_en_o, bus.rsp_valid_o} !== 5'b10000) begin
            $display("FAIL rst_mid_ctrl: got %b want 10000", {bus.req_ready_o, bus.busy_o, bus.md_mult_en_o, bus.md_div_en_o, bus.rsp_valid_o});
        end else passed++;
        total++;
        if ({bus.md_op_a_o, bus.md_op_b_o, bus.rsp_result_o, bus.rsp_rd_o, bus.cycles_o, bus.md_operator_o} !== '0) begin
            $display("FAIL rst_mid_payload: a=%h b=%h rd=%0d cyc=%0d op=%0d", bus.md_op_a_o, bus.md_op_b_o, bus.rsp_rd_o, bus.cycles_o, bus.md_operator_o);
        end else passed++;
        step();
        rst_n = 1'b1;
        step();
        issue(2'd0, 2'd0, 32'd2, 32'd2, 5'd5);
        wait_rsp(got);
        total++;
        if (!got || bus.rsp_result_o !== 32'd4 || int'(bus.cycles_o) != 3) begin
            $display("FAIL rst_mid_mull: valid=%b res=%0d cyc=%0d want 4 cyc 3", got, bus.rsp_result_o, bus.cycles_o);
        end else passed++;
        release_rsp();
    endtask

    task automatic test_random();
        logic [31:0] corner [4] = '{32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1};
        logic [1:0]  op, sm;
        logic [31:0] a, b;
        logic [4:0]  rd;
        bit          got;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            sm = op[1] ? {2{1'($urandom)}} : 2'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rd = 5'($urandom);
            issue(op, sm, a, b, rd);
            wait_rsp(got);
            repeat ($urandom_range(0, 3)) step();
            total++;
            if (!got || bus.rsp_result_o !== mdref(op, sm, a, b) || bus.rsp_rd_o !== rd) begin
                $display("FAIL rnd%0d_rsp: op=%0d sm=%0d a=%h b=%h got %h rd %0d want %h rd %0d", i, op, sm, a, b, bus.rsp_result_o, bus.rsp_rd_o, mdref(op, sm, a, b), rd);
            end else passed++;
            total++;
            if (int'(bus.cycles_o) != unit_lat(op, b == 0) || bus.md_op_a_o !== a || bus.md_op_b_o !== b) begin
                $display("FAIL rnd%0d_lat: cyc=%0d want %0d md_a=%h md_b=%h", i, bus.cycles_o, unit_lat(op, b == 0), bus.md_op_a_o, bus.md_op_b_o);
            end else passed++;
            release_rsp();
        end
    endtask

    initial begin
        bus.req_valid_i       = 1'b0;
        bus.req_operator_i    = '0;
        bus.req_signed_mode_i = '0;
        bus.req_op_a_i        = '0;
        bus.req_op_b_i        = '0;
        bus.req_rd_i          = '0;
        bus.flush_i           = 1'b0;
        bus.rsp_ready_i       = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_directed();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
